md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_pkg.sv | 36 +++
 rtl/md_ctrl_if.sv | 25 ++
 rtl/md_ctrl.sv | 101 ++++++++++
 tb/tb_md_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared multiply/divide opcode constants, FSM state encoding and opcode classifiers
// used by the MD controller, the decoder and the arithmetic unit.
package md_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // True for the four operations that occupy the arithmetic unit.
    function automatic logic is_arith(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_mult(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    // Any instruction that touches HI/LO or the arithmetic unit; 9..15 decode as none.
    function automatic logic is_md(input logic [3:0] op);
        return is_arith(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
               (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// Pipeline-to-MD-controller interface: opcodes from the E and D stages in,
// unit control, HI/LO write strobes and the D-stage stall out.
interface md_ctrl_if;

    logic [3:0] e_op;
    logic [3:0] d_op;
    logic       start;
    logic       busy;
    logic [3:0] cur_op;
    logic       hilo_we;
    logic       hi_we;
    logic       lo_we;
    logic       stall_d;

    modport master (
        output e_op, d_op,
        input  start, busy, cur_op, hilo_we, hi_we, lo_we, stall_d
    );

    modport slave (
        input  e_op, d_op,
        output start, busy, cur_op, hilo_we, hi_we, lo_we, stall_d
    );

endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: issues one operation at a time, counts its latency,
// pulses the HI/LO result write and stalls MD-class instructions in D meanwhile.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_ctrl_if.slave      bus
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

    md_state_e  state_r;
    logic [3:0] cnt_r;
    logic [3:0] cur_op_r;

    logic       start_s;
    logic       hi_we_s;
    logic       lo_we_s;
    logic       busy_s;
    logic       hilo_we_s;
    logic       stall_s;

    // Issue and mthi/mtlo strobes: only from IDLE, and reset overrides them.
    always_comb begin
        start_s = 1'b0;
        hi_we_s = 1'b0;
        lo_we_s = 1'b0;
        if ((state_r == ST_IDLE) && !reset) begin
            start_s = is_arith(bus.e_op);
            hi_we_s = (bus.e_op == OP_MTHI);
            lo_we_s = (bus.e_op == OP_MTLO);
        end else begin
            start_s = 1'b0;
            hi_we_s = 1'b0;
            lo_we_s = 1'b0;
        end
    end

    // Status and D-stage interlock; busy covers DONE so mfhi/mflo wait for the write.
    always_comb begin
        busy_s    = (state_r != ST_IDLE);
        hilo_we_s = (state_r == ST_DONE);
        stall_s   = is_md(bus.d_op) && (start_s || busy_s);
    end

    // Sequencer FSM with inline latency down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            cur_op_r <= OP_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r  <= ST_RUN;
                        cur_op_r <= bus.e_op;
                        cnt_r    <= is_mult(bus.e_op) ? MULT_CNT : DIV_CNT;
                    end else begin
                        state_r  <= ST_IDLE;
                        cur_op_r <= OP_NONE;
                        cnt_r    <= 4'd0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_DONE;
                        cnt_r   <= 4'd0;
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    cur_op_r <= OP_NONE;
                    cnt_r    <= 4'd0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cur_op_r <= OP_NONE;
                    cnt_r    <= 4'd0;
                end
            endcase
        end
    end

    assign bus.start   = start_s;
    assign bus.busy    = busy_s;
    assign bus.cur_op  = cur_op_r;
    assign bus.hilo_we = hilo_we_s;
    assign bus.hi_we   = hi_we_s;
    assign bus.lo_we   = lo_we_s;
    assign bus.stall_d = stall_s;

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed scenarios with cycle-relative expectations plus a
// randomized run checked against a timeline model (issue cycle + latency).
module tb_md_ctrl;

    localparam int ML = 5;
    localparam int DL = 10;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    md_ctrl_if bus ();

    md_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {start, busy, hilo_we, hi_we, lo_we, stall_d, cur_op}
    function automatic logic [9:0] obs();
        return {bus.start, bus.busy, bus.hilo_we, bus.hi_we, bus.lo_we, bus.stall_d, bus.cur_op};
    endfunction

    function automatic logic [9:0] vec(input logic st, input logic bz, input logic hl,
                                       input logic hw, input logic lw, input logic sd,
                                       input logic [3:0] op);
        return {st, bz, hl, hw, lw, sd, op};
    endfunction

    task automatic drive(input logic [3:0] e, input logic [3:0] d, input logic r);
        bus.e_op = e;
        bus.d_op = d;
        reset    = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] o;
        drive(4'd1, 4'd5, 1'b1);
        repeat (3) next_cycle();
        drive(4'd0, 4'd5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            o = obs();
            n_checks++;
            if (o !== 10'd0) begin
                $display("FAIL reset k=%0d got=%b exp=%b", k, o, 10'd0);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    task automatic test_mult();
        logic [9:0] o, e;
        for (int k = 0; k <= ML + 1; k++) begin
            drive((k == 0) ? 4'd1 : 4'd0, 4'd0, 1'b0);
            @(negedge clk);
            o = obs();
            e = vec(k == 0, k >= 1 && k <= ML, k == ML, 1'b0, 1'b0, 1'b0,
                    (k >= 1 && k <= ML) ? 4'd1 : 4'd0);
            n_checks++;
            if (o !== e) begin
                $display("FAIL mult k=%0d got=%b exp=%b", k, o, e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    task automatic test_divu();
        logic [9:0] o, e;
        logic [3:0] eop;
        for (int k = 0; k <= DL + 1; k++) begin
            if (k == 0)                  eop = 4'd4;
            else if (k >= 2 && k <= DL)  eop = 4'($urandom_range(1, 4));
            else                         eop = 4'd0;
            drive(eop, 4'd6, 1'b0);
            @(negedge clk);
            o = obs();
            e = vec(k == 0, k >= 1 && k <= DL, k == DL, 1'b0, 1'b0, k <= DL,
                    (k >= 1 && k <= DL) ? 4'd4 : 4'd0);
            n_checks++;
            if (o !== e) begin
                $display("FAIL divu k=%0d e_op=%0d got=%b exp=%b", k, eop, o, e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    task automatic test_mthi();
        logic [9:0] o, e;
        for (int k = 0; k <= ML + 3; k++) begin
            case (k)
                0:       drive(4'd7, 4'd0, 1'b0);
                1:       drive(4'd8, 4'd0, 1'b0);
                2:       drive(4'd1, 4'd0, 1'b0);
                4:       drive(4'd7, 4'd0, 1'b0);
                5:       drive(4'd8, 4'd0, 1'b0);
                default: drive(4'd0, 4'd0, 1'b0);
            endcase
            @(negedge clk);
            o = obs();
            e = vec(k == 2, k >= 3 && k <= ML + 2, k == ML + 2, k == 0, k == 1, 1'b0,
                    (k >= 3 && k <= ML + 2) ? 4'd1 : 4'd0);
            n_checks++;
            if (o !== e) begin
                $display("FAIL mthi k=%0d got=%b exp=%b", k, o, e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    task automatic test_non_md();
        logic [9:0] o, e;
        logic [3:0] dop;
        for (int k = 0; k <= ML + 1; k++) begin
            case (k)
                2:       dop = 4'd5;
                3:       dop = 4'd9;
                4:       dop = 4'd15;
                5:       dop = 4'd8;
                default: dop = 4'd0;
            endcase
            drive((k == 0) ? 4'd2 : 4'd0, dop, 1'b0);
            @(negedge clk);
            o = obs();
            e = vec(k == 0, k >= 1 && k <= ML, k == ML, 1'b0, 1'b0,
                    (dop >= 4'd1 && dop <= 4'd8) && (k <= ML),
                    (k >= 1 && k <= ML) ? 4'd2 : 4'd0);
            n_checks++;
            if (o !== e) begin
                $display("FAIL non_md k=%0d d_op=%0d got=%b exp=%b", k, dop, o, e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_op();
        logic [9:0] o;
        for (int k = 0; k <= 20; k++) begin
            drive((k == 0) ? 4'd3 : 4'd0, 4'd0, k == 4);
            @(negedge clk);
            o = obs();
            if (k >= 5) begin
                n_checks++;
                if (o !== 10'd0) begin
                    $display("FAIL reset_mid_op k=%0d got=%b exp=%b", k, o, 10'd0);
                    n_fail++;
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] o, e;
        int         p;
        for (int k = 0; k <= 2 * (ML + 1); k++) begin
            drive((k < 2 * (ML + 1)) ? 4'd1 : 4'd0, 4'd6, 1'b0);
            @(negedge clk);
            o = obs();
            p = k % (ML + 1);
            if (k == 2 * (ML + 1))
                e = 10'd0;
            else
                e = vec(p == 0, p != 0, p == ML, 1'b0, 1'b0, 1'b1, (p != 0) ? 4'd1 : 4'd0);
            n_checks++;
            if (o !== e) begin
                $display("FAIL back_to_back k=%0d got=%b exp=%b", k, o, e);
                n_fail++;
            end
            next_cycle();
        end
    endtask

    // Random opcodes; the model only tracks when the last operation was issued and how long it lasts.
    task automatic test_random();
        logic [9:0] o, e;
        logic [3:0] eop, dop;
        logic       rst, inflight, est, ebz;
        int         t0, lat;
        logic [3:0] op;
        t0  = -1000;
        lat = 0;
        op  = 4'd0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            eop = (rst || $urandom_range(0, 2) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
            dop = 4'($urandom_range(0, 15));
            drive(eop, dop, rst);
            @(negedge clk);
            inflight = (c > t0) && (c <= t0 + lat);
            ebz      = inflight;
            est      = !inflight && eop >= 4'd1 && eop <= 4'd4;
            e = vec(est, ebz, inflight && (c == t0 + lat),
                    !inflight && eop == 4'd7, !inflight && eop == 4'd8,
                    (dop >= 4'd1 && dop <= 4'd8) && (est || ebz),
                    inflight ? op : 4'd0);
            o = obs();
            n_checks++;
            if (o !== e) begin
                $display("FAIL random c=%0d e_op=%0d d_op=%0d rst=%0b got=%b exp=%b",
                         c, eop, dop, rst, o, e);
                n_fail++;
            end
            if (rst) begin
                t0 = -1000;
            end else if (est) begin
                t0  = c;
                lat = (eop <= 4'd2) ? ML : DL;
                op  = eop;
            end
            next_cycle();
        end
        drive(4'd0, 4'd0, 1'b0);
        repeat (DL + 2) next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(4'd0, 4'd0, 1'b1);
        test_reset();
        test_mult();
        test_divu();
        test_mthi();
        test_non_md();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
